obstacle_field: RTL and testbench
=================================

# obstacle_field

Parametrised obstacle manager for the Dino Run playfield: owns `NUM_SLOTS` independent obstacle slots, spawns cactus / high pterodactyl / low pterodactyl obstacles at the right screen edge with randomised spacing, and scrolls them left once per frame tick. It sits between the random-number source and the renderer/collision logic. It generalises the single-obstacle generator with multiple slots, safe unsigned retirement, a retirement pulse for scoring, and an optional speed ramp.

## Interface
- `NUM_SLOTS`, 2, number of concurrent obstacles (1..8)
- `H_W`, 10, width of horizontal/vertical coordinates
- `SCREEN_W`, 640, spawn reference; `SCREEN_W+60 < 2**H_W` required
- `SPAWN_GAP`, 320, newest obstacle's `h` must be at or below this before the next spawn
- `MAX_DELAY`, 20, extra random delay in steps, 0..`MAX_DELAY`
- `INIT_HVEL`, 5, scroll speed after reset, pixels/step
- `MAX_HVEL`, 15, speed-ramp ceiling (≤63)
- `SPEEDUP_PERIOD`, 8, retire events per +1 speed
- `clk` in 1 system clock
- `rst_n` in 1 reset, asynchronous, active-low
- `step` in 1 one-cycle frame-tick pulse; all state advances only when `step & enable`
- `enable` in 1 game running; low freezes everything
- `rand_num` in 8 free-running pseudo-random value
- `obstacle_active` out `NUM_SLOTS` per-slot valid
- `obstacle_h` out `NUM_SLOTS*H_W` packed upper-right-corner x, slot i at `[i*H_W +: H_W]`
- `obstacle_v` out `NUM_SLOTS*H_W` packed top y
- `obstacle_height` out `NUM_SLOTS*8` packed
- `obstacle_width` out `NUM_SLOTS*8` packed
- `obstacle_hvel` out 6 current scroll speed, shared
- `retire_pulse` out 1 one cycle high when ≥1 slot retired

## Operation
- Obstacle types from `rand_num % 3`: 0 cactus 80×30, `v=360`; 1 high pter 30×60, `v=375`; 2 low pter 30×60, `v=405`.
- Reference point is the upper-right corner; spawn sets `h = SCREEN_W + width`.
- Spawner FSM, transitions only on advance (`step & enable`):
  - `GAP`: leave when no slot active, or `h[last_slot] <= SPAWN_GAP`; latch `delay = rand_num % (MAX_DELAY+1)`, clear counter → `DELAY`.
  - `DELAY`: if `counter == delay` → `SPAWN`, else counter+1.
  - `SPAWN`: if any slot inactive, load lowest-index free slot (type from current `rand_num`), set `last_slot`, → `GAP`; if all full, stay.
- Movement per advance, each active slot: if `h <= hvel` retire (active←0, `h←SCREEN_W+width`, `v`/dims unchanged); else `h←h−hvel`. Never underflows.
- Free-slot test uses registered `active`: a slot retiring this advance is not spawnable until the next one. A slot spawned this advance is not moved this advance.
- `retire_pulse` is registered, high the cycle after any retirement, regardless of how many retired together.

## Timing
- Reset values: all `obstacle_active=0`, every `h=SCREEN_W+60`, `v=375`, height 30, width 60, `hvel=INIT_HVEL`, `retire_pulse=0`, FSM `GAP`, `last_slot=0`, counters 0.
- All outputs registered; an advance on edge N is visible after edge N.
- First spawn after reset: 1 advance (GAP) + `delay+1` advances (DELAY) + 1 (SPAWN).
- `step` held high multiple cycles advances every cycle; the block does not edge-detect.
- Reset mid-operation clears everything immediately, including in-flight delay.

## Configuration
- `OBSTACLE_SPEEDUP_EN` defined: retire-event counter; on reaching `SPEEDUP_PERIOD` it clears and `hvel` increments, saturating at `MAX_HVEL`.
- Undefined: `hvel` fixed at `INIT_HVEL`; no counter logic synthesised.

## Structure
- Package `obstacle_pkg`: type encoding (CACTUS/PTER_HIGH/PTER_LOW), per-type height/width/v constants, FSM state enum.
- Sub-module `obstacle_slot`: one slot's registers, load, move, retire; instantiated `NUM_SLOTS` times by a generate loop. Spawner FSM and speed logic stay in the top.

## Test plan
- Reset, `enable=1`, `step` every cycle, `rand_num=0`: slot 0 active at `h=670`, `v=360`, height 80, width 30 after 3 advances.
- Single slot, `hvel=5`, `h=670`: retires on the advance where `h=5`; `retire_pulse` one cycle; no wrap to ~1020.
- `NUM_SLOTS=2`, `rand_num=1`: second spawn only after slot 0 `h≤320`; lands in slot 1 at `h=700`, `v=375`.
- All slots full in `SPAWN`: FSM holds; spawns into the freed slot one advance after retirement.
- With `OBSTACLE_SPEEDUP_EN`, `SPEEDUP_PERIOD=2`: `hvel` 5→6 after 2nd retire; saturates at `MAX_HVEL`. Without macro: stays 5.
- `enable=0` mid-flight: positions/FSM frozen; `rst_n` low mid-delay: all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/obstacle_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : obstacle_pkg
//  Description : Shared types and constants for the Dino Run obstacle field:
//                obstacle type encoding, per-type geometry, spawner states.
//  Revision    : 1.0 - initial release
// ============================================================================
package obstacle_pkg;

    typedef enum logic [1:0] {
        CACTUS    = 2'd0,
        PTER_HIGH = 2'd1,
        PTER_LOW  = 2'd2
    } obs_type_t;

    typedef enum logic [1:0] {
        ST_GAP   = 2'd0,
        ST_DELAY = 2'd1,
        ST_SPAWN = 2'd2
    } spawn_state_t;

    localparam logic [7:0]  c_CACTUS_HEIGHT = 8'd80;
    localparam logic [7:0]  c_CACTUS_WIDTH  = 8'd30;
    localparam logic [7:0]  c_PTER_HEIGHT   = 8'd30;
    localparam logic [7:0]  c_PTER_WIDTH    = 8'd60;
    localparam int unsigned c_CACTUS_V      = 360;
    localparam int unsigned c_PTER_HIGH_V   = 375;
    localparam int unsigned c_PTER_LOW_V    = 405;

    // Reset geometry matches a high pterodactyl parked off-screen.
    localparam int unsigned c_RESET_V       = c_PTER_HIGH_V;
    localparam logic [7:0]  c_RESET_HEIGHT  = c_PTER_HEIGHT;
    localparam logic [7:0]  c_RESET_WIDTH   = c_PTER_WIDTH;

    function automatic obs_type_t type_from_rand(input logic [7:0] r);
        logic [7:0] m;
        m = r % 8'd3;
        return obs_type_t'(m[1:0]);
    endfunction

    function automatic logic [7:0] type_height(input obs_type_t t);
        return (t == CACTUS) ? c_CACTUS_HEIGHT : c_PTER_HEIGHT;
    endfunction

    function automatic logic [7:0] type_width(input obs_type_t t);
        return (t == CACTUS) ? c_CACTUS_WIDTH : c_PTER_WIDTH;
    endfunction

    function automatic int unsigned type_v(input obs_type_t t);
        case (t)
            CACTUS:    return c_CACTUS_V;
            PTER_HIGH: return c_PTER_HIGH_V;
            default:   return c_PTER_LOW_V;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/obstacle_field_slot.sv
`default_nettype none
// ============================================================================
//  Module      : obstacle_slot
//  Description : One obstacle slot. Holds position and geometry, loads a new
//                obstacle at the right edge, scrolls left on each advance and
//                retires without unsigned underflow.
//  Ports       : clk, rst_n          - clock, async active-low reset
//                i_advance           - frame advance (step & enable)
//                i_load              - spawn into this slot (only while idle)
//                i_load_height/width/v - geometry of the spawned obstacle
//                i_hvel              - current scroll speed
//                o_active/h/v/height/width - registered slot state
//                o_retire            - this slot retires on this advance
//  Revision    : 1.0 - initial release
// ============================================================================
module obstacle_slot
    import obstacle_pkg::*;
#(
    parameter int H_W      = 10,
    parameter int SCREEN_W = 640
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_advance,
    input  logic           i_load,
    input  logic [7:0]     i_load_height,
    input  logic [7:0]     i_load_width,
    input  logic [H_W-1:0] i_load_v,
    input  logic [5:0]     i_hvel,
    output logic           o_active,
    output logic [H_W-1:0] o_h,
    output logic [H_W-1:0] o_v,
    output logic [7:0]     o_height,
    output logic [7:0]     o_width,
    output logic           o_retire
);

    logic           r_active;
    logic [H_W-1:0] r_h;
    logic [H_W-1:0] r_v;
    logic [7:0]     r_height;
    logic [7:0]     r_width;

    // Retire when the next step would reach or pass x=0, so h never wraps.
    assign o_retire = i_advance & r_active & (r_h <= {{(H_W-6){1'b0}}, i_hvel});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_h      <= H_W'(SCREEN_W + 60);
            r_v      <= H_W'(c_RESET_V);
            r_height <= c_RESET_HEIGHT;
            r_width  <= c_RESET_WIDTH;
        end else if (i_load) begin
            r_active <= 1'b1;
            r_h      <= H_W'(SCREEN_W) + H_W'(i_load_width);
            r_v      <= i_load_v;
            r_height <= i_load_height;
            r_width  <= i_load_width;
        end else if (i_advance && r_active) begin
            if (o_retire) begin
                r_active <= 1'b0;
                r_h      <= H_W'(SCREEN_W) + H_W'(r_width);
            end else begin
                r_h <= r_h - {{(H_W-6){1'b0}}, i_hvel};
            end
        end
    end

    assign o_active = r_active;
    assign o_h      = r_h;
    assign o_v      = r_v;
    assign o_height = r_height;
    assign o_width  = r_width;

endmodule
`default_nettype wire

// File: rtl/obstacle_field.sv
`default_nettype none
// ============================================================================
//  Module      : obstacle_field
//  Description : Multi-slot obstacle manager. A spawner FSM waits for the
//                newest obstacle to clear the spawn gap, waits a random delay,
//                then loads the lowest free slot. Slots scroll left each
//                advance and raise a registered retire pulse when they leave.
//  Ports       : clk, rst_n          - clock, async active-low reset
//                step, enable        - state advances on step & enable
//                rand_num            - free-running random source
//                obstacle_active/h/v/height/width - packed per-slot outputs
//                obstacle_hvel       - shared scroll speed
//                retire_pulse        - one cycle after any slot retired
//  Options     : OBSTACLE_SPEEDUP_EN - speed ramps +1 every SPEEDUP_PERIOD
//                retire events, saturating at MAX_HVEL
//  Revision    : 1.0 - initial release
// ============================================================================
module obstacle_field
    import obstacle_pkg::*;
#(
    parameter int NUM_SLOTS      = 2,
    parameter int H_W            = 10,
    parameter int SCREEN_W       = 640,
    parameter int SPAWN_GAP      = 320,
    parameter int MAX_DELAY      = 20,
    parameter int INIT_HVEL      = 5,
    parameter int MAX_HVEL       = 15,
    parameter int SPEEDUP_PERIOD = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     step,
    input  logic                     enable,
    input  logic [7:0]               rand_num,
    output logic [NUM_SLOTS-1:0]     obstacle_active,
    output logic [NUM_SLOTS*H_W-1:0] obstacle_h,
    output logic [NUM_SLOTS*H_W-1:0] obstacle_v,
    output logic [NUM_SLOTS*8-1:0]   obstacle_height,
    output logic [NUM_SLOTS*8-1:0]   obstacle_width,
    output logic [5:0]               obstacle_hvel,
    output logic                     retire_pulse
);

    localparam int c_SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int c_DLY_W  = (MAX_DELAY > 0) ? $clog2(MAX_DELAY + 1) : 1;

    if ((NUM_SLOTS < 1) || (NUM_SLOTS > 8) || (SCREEN_W + 60 >= 2**H_W) ||
        (MAX_HVEL > 63) || (INIT_HVEL > MAX_HVEL) || (SPEEDUP_PERIOD < 1) ||
        (H_W < 6)) begin : g_bad_params
        $error("obstacle_field: illegal parameter combination");
    end

    logic                w_advance;
    spawn_state_t        r_state, w_state_next;
    logic [c_DLY_W-1:0]  r_delay, w_delay_next;
    logic [c_DLY_W-1:0]  r_count, w_count_next;
    logic [c_SLOT_W-1:0] r_last_slot, w_last_next;
    logic [NUM_SLOTS-1:0] w_load;
    logic [NUM_SLOTS-1:0] w_retire;
    logic                w_any_retire;
    logic                w_free_found;
    logic [c_SLOT_W-1:0] w_free_idx;
    logic [H_W-1:0]      w_slot_h [NUM_SLOTS];
    logic [H_W-1:0]      w_h_last;
    int unsigned         w_rand_mod;
    obs_type_t           w_spawn_type;
    logic                r_retire_pulse;
    logic [5:0]          r_hvel;

    assign w_advance    = step & enable;
    assign w_any_retire = |w_retire;
    assign w_spawn_type = type_from_rand(rand_num);
    assign w_rand_mod   = 32'(rand_num) % (MAX_DELAY + 1);
    assign w_h_last     = w_slot_h[r_last_slot];

    // ------------------------------------------------------------------
    // Slot array
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        obstacle_slot #(
            .H_W      (H_W),
            .SCREEN_W (SCREEN_W)
        ) u_slot (
            .clk           (clk),
            .rst_n         (rst_n),
            .i_advance     (w_advance),
            .i_load        (w_load[i]),
            .i_load_height (type_height(w_spawn_type)),
            .i_load_width  (type_width(w_spawn_type)),
            .i_load_v      (H_W'(type_v(w_spawn_type))),
            .i_hvel        (r_hvel),
            .o_active      (obstacle_active[i]),
            .o_h           (obstacle_h[i*H_W +: H_W]),
            .o_v           (obstacle_v[i*H_W +: H_W]),
            .o_height      (obstacle_height[i*8 +: 8]),
            .o_width       (obstacle_width[i*8 +: 8]),
            .o_retire      (w_retire[i])
        );
        assign w_slot_h[i] = obstacle_h[i*H_W +: H_W];
    end

    // Lowest-index idle slot, judged on registered state: a slot retiring
    // on this advance only becomes spawnable on the next one.
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!obstacle_active[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = c_SLOT_W'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Spawner FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_GAP;
            r_delay     <= '0;
            r_count     <= '0;
            r_last_slot <= '0;
        end else begin
            r_state     <= w_state_next;
            r_delay     <= w_delay_next;
            r_count     <= w_count_next;
            r_last_slot <= w_last_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_delay_next = r_delay;
        w_count_next = r_count;
        w_last_next  = r_last_slot;
        w_load       = '0;
        if (w_advance) begin
            case (r_state)
                ST_GAP: begin
                    if (!(|obstacle_active) || (w_h_last <= H_W'(SPAWN_GAP))) begin
                        w_delay_next = c_DLY_W'(w_rand_mod);
                        w_count_next = '0;
                        w_state_next = ST_DELAY;
                    end
                end
                ST_DELAY: begin
                    if (r_count == r_delay) begin
                        w_state_next = ST_SPAWN;
                    end else begin
                        w_count_next = r_count + c_DLY_W'(1);
                    end
                end
                ST_SPAWN: begin
                    // With every slot busy the FSM simply waits here.
                    if (w_free_found) begin
                        w_load[w_free_idx] = 1'b1;
                        w_last_next        = w_free_idx;
                        w_state_next       = ST_GAP;
                    end
                end
                default: w_state_next = ST_GAP;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Retire pulse and scroll speed
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retire_pulse <= 1'b0;
        end else begin
            r_retire_pulse <= w_any_retire;
        end
    end

`ifdef OBSTACLE_SPEEDUP_EN
    localparam int c_RCNT_W = (SPEEDUP_PERIOD > 1) ? $clog2(SPEEDUP_PERIOD) : 1;
    logic [c_RCNT_W-1:0] r_retire_cnt;

    // Simultaneous retirements count as a single event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retire_cnt <= '0;
            r_hvel       <= 6'(INIT_HVEL);
        end else if (w_any_retire) begin
            if (r_retire_cnt == c_RCNT_W'(SPEEDUP_PERIOD - 1)) begin
                r_retire_cnt <= '0;
                if (r_hvel < 6'(MAX_HVEL)) begin
                    r_hvel <= r_hvel + 6'd1;
                end
            end else begin
                r_retire_cnt <= r_retire_cnt + c_RCNT_W'(1);
            end
        end
    end
`else
    assign r_hvel = 6'(INIT_HVEL);
`endif

    assign obstacle_hvel = r_hvel;
    assign retire_pulse  = r_retire_pulse;

endmodule
`default_nettype wire

// File: tb/tb_obstacle_field.sv
`default_nettype none
// ============================================================================
//  Module      : tb_obstacle_field
//  Description : Scoreboard bench for obstacle_field. A reference model of
//                the playfield rules predicts every cycle's outputs into a
//                queue; a monitor pops and compares on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_obstacle_field;

    localparam int NS        = 3;
    localparam int HW        = 10;
    localparam int SCR_W     = 640;
    localparam int GAP       = 600;
    localparam int MAXD      = 7;
    localparam int INIT_V    = 5;
    localparam int MAXV      = 9;
    localparam int PERIOD    = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            step = 1'b0;
    logic            enable = 1'b0;
    logic [7:0]      rand_num = 8'd0;
    logic [NS-1:0]   obstacle_active;
    logic [NS*HW-1:0] obstacle_h, obstacle_v;
    logic [NS*8-1:0] obstacle_height, obstacle_width;
    logic [5:0]      obstacle_hvel;
    logic            retire_pulse;

    obstacle_field #(
        .NUM_SLOTS(NS), .H_W(HW), .SCREEN_W(SCR_W), .SPAWN_GAP(GAP),
        .MAX_DELAY(MAXD), .INIT_HVEL(INIT_V), .MAX_HVEL(MAXV),
        .SPEEDUP_PERIOD(PERIOD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .step(step), .enable(enable),
        .rand_num(rand_num), .obstacle_active(obstacle_active),
        .obstacle_h(obstacle_h), .obstacle_v(obstacle_v),
        .obstacle_height(obstacle_height), .obstacle_width(obstacle_width),
        .obstacle_hvel(obstacle_hvel), .retire_pulse(retire_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NS-1:0]    act;
        logic [NS*HW-1:0] h;
        logic [NS*HW-1:0] v;
        logic [NS*8-1:0]  ht;
        logic [NS*8-1:0]  wd;
        logic [5:0]       hvel;
        logic             rp;
    } snap_t;

    snap_t q[$];
    int n_cmp = 0;
    int n_bad = 0;
    bit started = 0;

    // Playfield geometry per type index 0..2 (cactus, high pter, low pter).
    int t_ht[3] = '{80, 30, 30};
    int t_wd[3] = '{30, 60, 60};
    int t_v [3] = '{360, 375, 405};

    // Reference model state.
    bit m_act[NS];
    int m_h[NS], m_v[NS], m_ht[NS], m_wd[NS];
    int m_hvel, m_retires, m_last;
    bit m_rp;
    // -1: waiting for the spawn gap; >0: delay advances left; 0: try to spawn
    int wait_left;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            m_act[i] = 0; m_h[i] = SCR_W + 60; m_v[i] = 375; m_ht[i] = 30; m_wd[i] = 60;
        end
        m_hvel = INIT_V; m_retires = 0; m_last = 0; m_rp = 0; wait_left = -1;
    endtask

    task automatic model_advance(input int r);
        int spawn_slot;
        bit any_active, any_ret;
        spawn_slot = -1;
        any_active = 0;
        for (int i = 0; i < NS; i++) any_active |= m_act[i];
        // Spawner decisions see the state before this advance's movement.
        if (wait_left < 0) begin
            if (!any_active || m_h[m_last] <= GAP) wait_left = (r % (MAXD + 1)) + 1;
        end else if (wait_left > 0) begin
            wait_left--;
        end else begin
            for (int i = NS - 1; i >= 0; i--) if (!m_act[i]) spawn_slot = i;
        end
        any_ret = 0;
        for (int i = 0; i < NS; i++) begin
            if (m_act[i]) begin
                if (m_h[i] <= m_hvel) begin
                    m_act[i] = 0; m_h[i] = SCR_W + m_wd[i]; any_ret = 1;
                end else begin
                    m_h[i] = m_h[i] - m_hvel;
                end
            end
        end
        if (spawn_slot >= 0) begin
            m_act[spawn_slot] = 1;
            m_ht[spawn_slot]  = t_ht[r % 3];
            m_wd[spawn_slot]  = t_wd[r % 3];
            m_v[spawn_slot]   = t_v[r % 3];
            m_h[spawn_slot]   = SCR_W + t_wd[r % 3];
            m_last = spawn_slot;
            wait_left = -1;
        end
        m_rp = any_ret;
`ifdef OBSTACLE_SPEEDUP_EN
        if (any_ret) begin
            m_retires++;
            if (m_retires == PERIOD) begin
                m_retires = 0;
                if (m_hvel < MAXV) m_hvel++;
            end
        end
`endif
    endtask

    function automatic snap_t model_snap();
        snap_t s;
        for (int i = 0; i < NS; i++) begin
            s.act[i]          = m_act[i];
            s.h[i*HW +: HW]   = HW'(m_h[i]);
            s.v[i*HW +: HW]   = HW'(m_v[i]);
            s.ht[i*8 +: 8]    = 8'(m_ht[i]);
            s.wd[i*8 +: 8]    = 8'(m_wd[i]);
        end
        s.hvel = 6'(m_hvel);
        s.rp   = m_rp;
        return s;
    endfunction

    // Model: mirrors the block's register update on every clock edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
            if (clk) begin
                q.push_back(model_snap());
                started = 1;
            end
        end else begin
            if (step && enable) model_advance(int'(rand_num));
            else m_rp = 0;
            q.push_back(model_snap());
            started = 1;
        end
    end

    // Monitor: compare DUT outputs against the oldest prediction.
    always @(negedge clk) begin
        snap_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("active", 64'(obstacle_active), 64'(e.act));
            check("h",      64'(obstacle_h),      64'(e.h));
            check("v",      64'(obstacle_v),      64'(e.v));
            check("height", 64'(obstacle_height), 64'(e.ht));
            check("width",  64'(obstacle_width),  64'(e.wd));
            check("hvel",   64'(obstacle_hvel),   64'(e.hvel));
            check("retire_pulse", 64'(retire_pulse), 64'(e.rp));
        end else if (started) begin
            check("scoreboard_underflow", 64'(q.size()), 64'd1);
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_active"}, 64'(obstacle_active), 64'd0);
        check({tag, "_hvel"},   64'(obstacle_hvel),   64'(INIT_V));
        check({tag, "_pulse"},  64'(retire_pulse),    64'd0);
        for (int i = 0; i < NS; i++) begin
            check({tag, "_h"},      64'(obstacle_h[i*HW +: HW]),    64'(SCR_W + 60));
            check({tag, "_v"},      64'(obstacle_v[i*HW +: HW]),    64'd375);
            check({tag, "_height"}, 64'(obstacle_height[i*8 +: 8]), 64'd30);
            check({tag, "_width"},  64'(obstacle_width[i*8 +: 8]),  64'd60);
        end
    endtask

    task automatic drive_random(input int cycles, input bit freeze);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk); #2;
            step     = ($urandom_range(0, 3) != 0);
            enable   = freeze ? 1'b0 : ($urandom_range(0, 15) != 0);
            rand_num = 8'($urandom_range(0, 255));
        end
    endtask

    initial begin
        // Power-on reset held across a few edges.
        repeat (3) @(negedge clk);
        #1;
        check_reset_values("por");
        // Directed first spawn: rand 0 gives a cactus after three advances.
        #1;
        rst_n = 1'b1; step = 1'b1; enable = 1'b1; rand_num = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("first_spawn_active", 64'(obstacle_active[0]), 64'd1);
        check("first_spawn_h",      64'(obstacle_h[0 +: HW]), 64'd670);
        check("first_spawn_v",      64'(obstacle_v[0 +: HW]), 64'd360);
        check("first_spawn_height", 64'(obstacle_height[0 +: 8]), 64'd80);
        check("first_spawn_width",  64'(obstacle_width[0 +: 8]), 64'd30);

        drive_random(1500, 1'b0);
        drive_random(40, 1'b1);           // frozen playfield
        drive_random(600, 1'b0);

        // Asynchronous reset mid-flight, away from any clock edge.
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        drive_random(1500, 1'b0);

        @(negedge clk); #2;
        step = 1'b0; enable = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
